// File: rtl/mem_stage.sv
// MIPS memory-access stage: turns held EX/MEM contents into one data-SRAM
// transaction (req/addr_ok/data_ok), stalls the pipe meanwhile, aligns loads.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  MEM_in_memop,
  input  logic [31:0] MEM_in_ALUresult,
  input  logic [31:0] MEM_in_data_sram_addr,
  input  logic [31:0] MEM_in_data_sram_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        MEM_stall,
  output logic [31:0] MEM_out_result,
  output logic        MEM_out_adel,
  output logic        MEM_out_ades
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_ld;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_signed;
  logic            w_is_mem;
  logic            w_misalign;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_ld_val;
  logic [DW-1:0]   w_wdata;
  logic [1:0]      w_size;

  // Opcode decode; codes 9..15 fall through as non-memory ops
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_signed   = 1'b0;
    case (MEM_in_memop)
      4'd1: begin w_is_load  = 1'b1; w_is_byte = 1'b1; w_signed = 1'b1; end
      4'd2: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
      4'd3: begin w_is_load  = 1'b1; w_is_half = 1'b1; w_signed = 1'b1; end
      4'd4: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
      4'd5: begin w_is_load  = 1'b1; w_is_word = 1'b1; end
      4'd6: begin w_is_store = 1'b1; w_is_byte = 1'b1; end
      4'd7: begin w_is_store = 1'b1; w_is_half = 1'b1; end
      4'd8: begin w_is_store = 1'b1; w_is_word = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = (w_is_half & MEM_in_data_sram_addr[0]) |
                      (w_is_word & (|MEM_in_data_sram_addr[1:0]));

  // Load lane selection and extension
  always_comb begin
    case (MEM_in_data_sram_addr[1:0])
      2'd0:    w_byte = data_rdata[7:0];
      2'd1:    w_byte = data_rdata[15:8];
      2'd2:    w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = MEM_in_data_sram_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    if (w_is_byte)
      w_ld_val = {{24{w_signed & w_byte[7]}}, w_byte};
    else if (w_is_half)
      w_ld_val = {{16{w_signed & w_half[15]}}, w_half};
    else
      w_ld_val = data_rdata;
  end

  // Store lane replication and request size
  always_comb begin
    if (w_is_byte) begin
      w_wdata = {4{MEM_in_data_sram_wdata[7:0]}};
      w_size  = 2'd0;
    end else if (w_is_half) begin
      w_wdata = {2{MEM_in_data_sram_wdata[15:0]}};
      w_size  = 2'd1;
    end else begin
      w_wdata = MEM_in_data_sram_wdata;
      w_size  = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ld    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_is_mem && !w_misalign && data_addr_ok) r_state <= S_WAIT;
        S_WAIT: if (data_data_ok) begin
          if (w_is_load) r_ld <= w_ld_val;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall and bus outputs follow the held EX/MEM inputs within the cycle
  always_comb begin
    data_req       = 1'b0;
    data_wr        = 1'b0;
    data_size      = 2'd0;
    data_addr      = '0;
    data_wdata     = '0;
    MEM_stall      = 1'b0;
    MEM_out_result = '0;
    MEM_out_adel   = 1'b0;
    MEM_out_ades   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          MEM_out_result = MEM_in_ALUresult;
          if (w_is_mem && w_misalign) begin
            MEM_out_adel   = w_is_load;
            MEM_out_ades   = w_is_store;
            MEM_out_result = MEM_in_data_sram_addr;
          end else if (w_is_mem) begin
            data_req   = 1'b1;
            MEM_stall  = 1'b1;
            data_wr    = w_is_store;
            data_size  = w_size;
            data_addr  = MEM_in_data_sram_addr;
            data_wdata = w_wdata;
          end
        end
        S_WAIT: begin
          MEM_stall      = 1'b1;
          MEM_out_result = MEM_in_ALUresult;
        end
        S_DONE:  MEM_out_result = w_is_load ? r_ld : MEM_in_ALUresult;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle compare against an arithmetic model
// of the stage, plus literal expectations for the hand-worked cases.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  MEM_in_memop;
  logic [31:0] MEM_in_ALUresult;
  logic [31:0] MEM_in_data_sram_addr;
  logic [31:0] MEM_in_data_sram_wdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        MEM_stall;
  logic [31:0] MEM_out_result;
  logic        MEM_out_adel;
  logic        MEM_out_ades;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .MEM_in_memop(MEM_in_memop),
    .MEM_in_ALUresult(MEM_in_ALUresult),
    .MEM_in_data_sram_addr(MEM_in_data_sram_addr),
    .MEM_in_data_sram_wdata(MEM_in_data_sram_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .MEM_stall(MEM_stall), .MEM_out_result(MEM_out_result),
    .MEM_out_adel(MEM_out_adel), .MEM_out_ades(MEM_out_ades)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Expected outputs for the current cycle, set by the driver
  logic        e_chk = 1'b0;
  logic        e_req, e_stall, e_adel, e_ades;
  logic        e_res_chk, e_bus_chk;
  logic [31:0] e_res;
  logic        e_wr;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (e_chk) begin
      chk("data_req",  32'(data_req),     32'(e_req));
      chk("MEM_stall", 32'(MEM_stall),    32'(e_stall));
      chk("adel",      32'(MEM_out_adel), 32'(e_adel));
      chk("ades",      32'(MEM_out_ades), 32'(e_ades));
      if (e_res_chk) chk("result", MEM_out_result, e_res);
      if (e_bus_chk) begin
        chk("data_wr",    32'(data_wr),   32'(e_wr));
        chk("data_size",  32'(data_size), 32'(e_size));
        chk("data_addr",  data_addr,      e_addr);
        chk("data_wdata", data_wdata,     e_wdata);
      end
    end
  end

  // ---- specification model, plain arithmetic ----
  function automatic bit m_is_load(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction
  function automatic bit m_is_store(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction
  function automatic logic [1:0] m_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 2'd0;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2'd1;
    return 2'd2;
  endfunction
  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
    if (m_size(op) == 2'd1) return (a % 2) != 0;
    if (m_size(op) == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction
  function automatic logic [31:0] m_lanes(input logic [3:0] op, input logic [31:0] wd);
    if (op == 4'd6) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == 4'd7) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction
  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    if (op == 4'd1 || op == 4'd2) begin
      v = longint'((rd >> (8 * (a % 4))) & 32'hFF);
      if (op == 4'd1 && v >= 128) v = v - 256;
    end else if (op == 4'd3 || op == 4'd4) begin
      v = longint'((rd >> (16 * ((a / 2) % 2))) & 32'hFFFF);
      if (op == 4'd3 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One EX/MEM instruction: aok_wait cycles before addr_ok, n_wait WAIT cycles
  task automatic do_op(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int aok_wait, input int n_wait,
                       output logic [31:0] res, output int stall_cnt,
                       output logic [31:0] seen_wdata);
    bit ld, st, mis;
    ld  = m_is_load(op);
    st  = m_is_store(op);
    mis = (ld || st) && m_mis(op, a);
    MEM_in_memop = op; MEM_in_ALUresult = alu;
    MEM_in_data_sram_addr = a; MEM_in_data_sram_wdata = wd;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    stall_cnt = 0; seen_wdata = '0;
    e_adel = 1'b0; e_ades = 1'b0; e_chk = 1'b1;
    if (!(ld || st) || mis) begin
      e_req = 1'b0; e_stall = 1'b0; e_bus_chk = 1'b0;
      e_adel = ld && mis; e_ades = st && mis;
      e_res_chk = 1'b1; e_res = mis ? a : alu;
      data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;  // stray ack must be ignored
      @(negedge clk); #1;
      res = MEM_out_result;
      tick();
      data_data_ok = 1'b0;
      return;
    end
    e_req = 1'b1; e_stall = 1'b1; e_res_chk = 1'b0; e_bus_chk = 1'b1;
    e_wr = st; e_size = m_size(op); e_addr = a; e_wdata = m_lanes(op, wd);
    for (int i = 0; i <= aok_wait; i++) begin
      data_addr_ok = (i == aok_wait);
      @(negedge clk); #1;
      stall_cnt += int'(MEM_stall);
      seen_wdata = data_wdata;
      tick();
    end
    data_addr_ok = 1'b0;
    e_req = 1'b0; e_bus_chk = 1'b0;
    for (int i = 1; i <= n_wait; i++) begin
      data_data_ok = (i == n_wait);
      data_rdata   = (i == n_wait) ? rd : ~rd;
      @(negedge clk); #1;
      stall_cnt += int'(MEM_stall);
      tick();
    end
    data_data_ok = 1'b0; data_rdata = '0;
    e_stall = 1'b0; e_res_chk = 1'b1;
    e_res = ld ? m_load(op, a, rd) : alu;
    @(negedge clk); #1;
    res = MEM_out_result;
    stall_cnt += int'(MEM_stall);
    tick();
  endtask

  task automatic exp_reset();
    e_req = 1'b0; e_stall = 1'b0; e_adel = 1'b0; e_ades = 1'b0;
    e_res_chk = 1'b1; e_res = '0;
    e_bus_chk = 1'b1; e_wr = 1'b0; e_size = 2'd0; e_addr = '0; e_wdata = '0;
    e_chk = 1'b1;
  endtask

  logic [31:0] res, wseen;
  int          sc;

  initial begin
    // Reset with an aligned LW and addr_ok present: nothing may be issued
    rst = 1'b1;
    MEM_in_memop = 4'd5; MEM_in_ALUresult = 32'h1111_1111;
    MEM_in_data_sram_addr = 32'h0000_0040; MEM_in_data_sram_wdata = 32'h0;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0;
    exp_reset();
    tick(); tick();
    rst = 1'b0;

    do_op(4'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0, 0, res, sc, wseen);
    chk("nonmem_result", res, 32'h0000_1234);

    do_op(4'd5, 32'h9, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 3, res, sc, wseen);
    chk("lw_result", res, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", 32'(sc), 32'd6);

    do_op(4'd1, 32'h0, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 0, 1, res, sc, wseen);
    chk("lb_result", res, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(sc), 32'd2);
    do_op(4'd2, 32'h0, 32'h0000_1003, 32'h0, 32'h80FF_FF11, 1, 2, res, sc, wseen);
    chk("lbu_result", res, 32'h0000_0080);

    do_op(4'd3, 32'h0, 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 2, res, sc, wseen);
    chk("lh_result", res, 32'hFFFF_8001);
    do_op(4'd4, 32'h0, 32'h0000_1002, 32'h0, 32'h8001_0000, 1, 1, res, sc, wseen);
    chk("lhu_result", res, 32'h0000_8001);

    do_op(4'd7, 32'h0000_1002, 32'h0000_1002, 32'h1234_ABCD, 32'h0, 1, 2, res, sc, wseen);
    chk("sh_wdata", wseen, 32'hABCD_ABCD);
    chk("sh_result", res, 32'h0000_1002);

    do_op(4'd6, 32'h77, 32'h0000_2001, 32'h0000_0077, 32'h0, 0, 1, res, sc, wseen);
    chk("sb_wdata", wseen, 32'h7777_7777);
    do_op(4'd8, 32'h5, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 0, 1, res, sc, wseen);
    chk("sw_wdata", wseen, 32'hCAFE_F00D);
    do_op(4'd2, 32'h0, 32'h0000_2000, 32'h0, 32'h1234_56F0, 0, 1, res, sc, wseen);
    chk("lbu_off0_result", res, 32'h0000_00F0);

    do_op(4'd3, 32'h0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, res, sc, wseen);
    chk("lh_misalign_result", res, 32'h0000_1001);
    do_op(4'd8, 32'h0, 32'h0000_1002, 32'h0, 32'h0, 0, 0, res, sc, wseen);
    chk("sw_misalign_result", res, 32'h0000_1002);
    do_op(4'd5, 32'h0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, res, sc, wseen);
    do_op(4'd12, 32'h0000_ABCD, 32'h0000_0003, 32'h0, 32'h0, 0, 0, res, sc, wseen);
    chk("op12_result", res, 32'h0000_ABCD);

    // Reset while in WAIT, then a late data_ok
    MEM_in_memop = 4'd5; MEM_in_ALUresult = 32'h0;
    MEM_in_data_sram_addr = 32'h0000_3000; data_addr_ok = 1'b1;
    e_req = 1'b1; e_stall = 1'b1; e_adel = 1'b0; e_ades = 1'b0;
    e_res_chk = 1'b0; e_bus_chk = 1'b1; e_wr = 1'b0; e_size = 2'd2;
    e_addr = 32'h0000_3000; e_wdata = MEM_in_data_sram_wdata;
    tick();
    data_addr_ok = 1'b0; e_req = 1'b0; e_bus_chk = 1'b0;
    tick();
    rst = 1'b1; exp_reset();
    tick();
    rst = 1'b0;
    MEM_in_memop = 4'd0; MEM_in_ALUresult = 32'h0000_0055;
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    e_req = 1'b0; e_stall = 1'b0; e_bus_chk = 1'b0; e_res_chk = 1'b1; e_res = 32'h0000_0055;
    @(negedge clk); #1;
    chk("rst_wait_stall", 32'(MEM_stall), 32'd0);
    chk("rst_wait_ld_r", dut.r_ld, 32'h0);
    tick();
    data_data_ok = 1'b0;

    do_op(4'd5, 32'h0, 32'h0000_3004, 32'h0, 32'h0BAD_CAFE, 0, 1, res, sc, wseen);
    chk("lw_after_rst", res, 32'h0BAD_CAFE);

    e_chk = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding MEM/WB. It turns the held EX/MEM contents into a data-SRAM transaction over a req/addr_ok/data_ok handshake. While a transaction is in flight it holds the pipeline with `MEM_stall`. It returns aligned, extended load data, or the ALU result for non-load instructions, and flags misaligned accesses.

## Interface
Parameters: none.
- `clk`  in  1  clock
- `rst`  in  1  reset: rst, synchronous, active-high; clock clk
- `MEM_in_memop`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- `MEM_in_ALUresult`  in  32  ALU result from EX/MEM
- `MEM_in_data_sram_addr`  in  32  effective address
- `MEM_in_data_sram_wdata`  in  32  store data, right-justified
- `data_req`  out  1  request valid
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  request address, full byte address
- `data_wdata`  out  32  lane-replicated store data
- `data_addr_ok`  in  1  request accepted this cycle
- `data_data_ok`  in  1  read data or write ack valid
- `data_rdata`  in  32  read data, full word
- `MEM_stall`  out  1  hold EX/MEM and all upstream stages
- `MEM_out_result`  out  32  value to MEM/WB
- `MEM_out_adel`  out  1  load address error
- `MEM_out_ades`  out  1  store address error

## Operation
- FSM states:
  - IDLE → REQ-accepted → WAIT → DONE → IDLE.
  - Reset state is IDLE.
  - State encoding and a 32-bit load-result register `ld_r` are the only sequential state.
- Misalignment check, IDLE only:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - Misaligned access: no request; `adel` is set for loads, `ades` for stores; `MEM_stall`=0; `MEM_out_result`=address; FSM stays IDLE.
- IDLE with a non-memory op: `data_req`=0, `MEM_stall`=0, `MEM_out_result`=`MEM_in_ALUresult`.
- IDLE with an aligned memory op:
  - Outputs: `data_req`=1, `MEM_stall`=1, `data_wr`=1 for SB/SH/SW, `data_addr`=address.
  - `data_size`: byte ops 0, half ops 1, word ops 2.
  - If `data_addr_ok`=1 this cycle, go to WAIT; otherwise stay in IDLE with the request held stable.
- Store data lanes: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata.
- WAIT:
  - `data_req`=0, `MEM_stall`=1.
  - On `data_data_ok`, capture the aligned load value into `ld_r` (stores capture nothing) and go to DONE.
- Load alignment:
  - LB/LBU select rdata byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata unchanged.
- DONE:
  - `MEM_stall`=0.
  - `MEM_out_result`=`ld_r` for loads, `MEM_in_ALUresult` for stores.
  - Always go to IDLE next cycle; EX/MEM advances on this edge.
- Error flags are combinational in IDLE only; they are 0 in WAIT and DONE.

## Timing
- Reset values while `rst`=1 and on the first cycle after: state IDLE, `ld_r`=0.
- During `rst`=1, all outputs are forced: `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wdata`=0, `MEM_stall`=0, `adel`=`ades`=0, `MEM_out_result`=0.
- Minimum memory-op latency is 3 cycles: request with addr_ok (IDLE), data_ok (WAIT), DONE.
- Total stall = (cycles until addr_ok, inclusive) + (cycles in WAIT).
- `data_data_ok` is honoured only in WAIT:
  - In the addr_ok cycle it is ignored; the slave never returns data in the same cycle as addr_ok.
  - In IDLE or DONE it is ignored.
- `data_req` never drops before `data_addr_ok`; address, size and data stay constant while `data_req`=1.
- Reset mid-transaction (WAIT): return to IDLE, clear `ld_r`; a late `data_data_ok` after reset is ignored.
- Simultaneous rst and addr_ok: rst wins, and no transaction is considered issued.
- Non-memory ops add zero stall cycles.

## Test plan
- **Non-memory op:** memop=0, ALUresult=0x0000_1234 → `MEM_stall`=0, `data_req`=0, result=0x0000_1234 in the same cycle.
- **LW with handshake delay:** LW at 0x0000_1000; addr_ok held off 2 cycles, then data_ok 3 cycles later with rdata=0xDEAD_BEEF → `MEM_stall` high for 6 cycles; DONE result=0xDEAD_BEEF; `data_req` never drops early.
- **Byte loads at offset 3:** rdata=0x80FF_FF11 → LB at 0x...3 yields 0xFFFF_FF80; LBU at 0x...3 yields 0x0000_0080.
- **Halfword loads:** LH at 0x...2 with rdata=0x8001_0000 → 0xFFFF_8001; LHU → 0x0000_8001.
- **SH lane replication:** SH at 0x...2 with wdata=0x1234_ABCD → `data_wr`=1, size=1, `data_wdata`=0xABCD_ABCD; completes on the data_ok ack.
- **Misaligned and reset cases:**
  - LH at 0x0000_1001 → `adel`=1, `data_req`=0, result=0x0000_1001.
  - SW at 0x...2 → `ades`=1.
  - rst asserted in WAIT, then data_ok → FSM in IDLE, `MEM_stall`=0, `ld_r`=0.
